// File: rtl/sargantana_icache_refill_writer_pkg.sv
// rtl/sargantana_icache_refill_writer_pkg.sv - shared geometry constants and refill FSM state type
package sargantana_icache_pkg;

    localparam int SET_WIDHT  = 128;
    localparam int ADDR_WIDHT = 8;
    localparam int BEAT_W     = 64;
    localparam int N_WAYS     = 4;
    localparam int N_BEATS    = SET_WIDHT / BEAT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } refill_state_t;

endpackage

// File: rtl/sargantana_icache_refill_writer_if.sv
// rtl/sargantana_icache_refill_writer_if.sv - L2 refill beat channel (signal suffixes are from the writer's side)
interface sargantana_icache_refill_writer_if
    import sargantana_icache_pkg::*;
#(
    parameter int P_BEAT_W = BEAT_W,
    parameter int P_ADDR_W = ADDR_WIDHT,
    parameter int P_N_WAYS = N_WAYS
);
    logic                refill_valid_i;
    logic                refill_ready_o;
    logic [P_BEAT_W-1:0] refill_data_i;
    logic [P_ADDR_W-1:0] refill_idx_i;
    logic [P_N_WAYS-1:0] refill_way_i;
    logic                refill_abort_i;

    modport master (
        output refill_valid_i, refill_data_i, refill_idx_i, refill_way_i, refill_abort_i,
        input  refill_ready_o
    );

    modport slave (
        input  refill_valid_i, refill_data_i, refill_idx_i, refill_way_i, refill_abort_i,
        output refill_ready_o
    );
endinterface

// File: rtl/sargantana_icache_refill_writer_line_assembler.sv
// rtl/sargantana_icache_refill_writer_line_assembler.sv - packs refill beats LSB-first into one line
module sargantana_icache_line_assembler #(
    parameter int SET_WIDHT = 128,
    parameter int BEAT_W    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 beat_valid_i,
    input  logic [BEAT_W-1:0]    beat_data_i,
    input  logic                 clear_i,
    output logic [SET_WIDHT-1:0] line_o,
    output logic                 last_beat_o
);
    localparam int N_BEATS = SET_WIDHT / BEAT_W;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [SET_WIDHT-1:0] line_q, line_d;

    assign last_beat_o = (beat_cnt_q == CNT_W'(N_BEATS - 1));
    assign line_o      = line_q;

    // clear has priority so an abort arriving with a beat consumes it without storing
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        if (clear_i) begin
            beat_cnt_d = '0;
            line_d     = '0;
        end else if (beat_valid_i) begin
            line_d[int'(beat_cnt_q) * BEAT_W +: BEAT_W] = beat_data_i;
            beat_cnt_d = last_beat_o ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
        end
    end
endmodule

// File: rtl/sargantana_icache_refill_writer.sv
// rtl/sargantana_icache_refill_writer.sv - refill FSM driving the icache way write ports
// Optional flush sweep enabled by defining ICACHE_REFILL_FLUSH_EN.
module sargantana_icache_refill_writer
    import sargantana_icache_pkg::*;
#(
    parameter int P_SET_WIDHT  = SET_WIDHT,
    parameter int P_ADDR_WIDHT = ADDR_WIDHT,
    parameter int P_BEAT_W     = BEAT_W,
    parameter int P_N_WAYS     = N_WAYS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    sargantana_icache_refill_writer_if.slave refill,
    input  logic                     flush_i,
    output logic [P_N_WAYS-1:0]      way_req_o,
    output logic                     way_we_o,
    output logic [P_ADDR_WIDHT-1:0]  way_addr_o,
    output logic [P_SET_WIDHT-1:0]   way_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     flush_done_o
);
    refill_state_t             state_q, state_d;
    logic [P_ADDR_WIDHT-1:0]   idx_q;
    logic [P_N_WAYS-1:0]       way_q;
    logic [P_SET_WIDHT-1:0]    line;
    logic                      last_beat;
    logic                      ready;
    logic                      accept;
    logic                      abort;
    logic                      flush_go;

    assign accept = refill.refill_valid_i & ready;
    assign abort  = refill.refill_abort_i & ((state_q == IDLE) | (state_q == FILL));
    assign refill.refill_ready_o = ready;

`ifdef ICACHE_REFILL_FLUSH_EN
    logic [P_ADDR_WIDHT-1:0] flush_cnt_q;
    logic                    flush_last;

    assign flush_go   = (state_q == IDLE) & flush_i;
    assign flush_last = (flush_cnt_q == {P_ADDR_WIDHT{1'b1}});

    // counter sits at 0 outside FLUSH and wraps back to 0 after the last entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            flush_cnt_q <= '0;
        else if (state_q == FLUSH)
            flush_cnt_q <= flush_cnt_q + 1'b1;
        else
            flush_cnt_q <= '0;
    end
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush_go     = 1'b0;
`endif

    sargantana_icache_line_assembler #(
        .SET_WIDHT (P_SET_WIDHT),
        .BEAT_W    (P_BEAT_W)
    ) u_line_assembler (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .beat_valid_i (accept),
        .beat_data_i  (refill.refill_data_i),
        .clear_i      (abort | (state_q == WRITE)),
        .line_o       (line),
        .last_beat_o  (last_beat)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && accept && !abort) begin
                idx_q <= refill.refill_idx_i;
                way_q <= refill.refill_way_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_go)
                    state_d = FLUSH;
                else if (accept && !abort)
                    state_d = last_beat ? WRITE : FILL;
            end
            FILL: begin
                if (abort)
                    state_d = IDLE;
                else if (accept && last_beat)
                    state_d = WRITE;
            end
            WRITE: state_d = IDLE;
`ifdef ICACHE_REFILL_FLUSH_EN
            FLUSH: begin
                if (flush_last)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready        = 1'b0;
        way_req_o    = '0;
        way_we_o     = 1'b0;
        way_addr_o   = '0;
        way_data_o   = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        flush_done_o = 1'b0;
        case (state_q)
            IDLE: ready = !flush_go;
            FILL: begin
                ready  = 1'b1;
                busy_o = 1'b1;
            end
            WRITE: begin
                busy_o     = 1'b1;
                way_req_o  = way_q;
                way_we_o   = 1'b1;
                way_addr_o = idx_q;
                way_data_o = line;
                done_o     = 1'b1;
            end
`ifdef ICACHE_REFILL_FLUSH_EN
            FLUSH: begin
                busy_o       = 1'b1;
                way_req_o    = '1;
                way_we_o     = 1'b1;
                way_addr_o   = flush_cnt_q;
                flush_done_o = flush_last;
            end
`endif
            default: ;
        endcase
    end

    // way select is expected to be one-hot; a malformed select is still written as given
    assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_q == IDLE) && accept && !abort && !flush_go) |-> $onehot(refill.refill_way_i));

endmodule
